cs_dat: RTL
===========

# cs_dat

Data-acquisition sequencer for the capture path. It polls the enabled ADC devices round-robin, one at a time, over a four-phase fs/fd handshake. After `adc_cnt` full rounds it hands one packet to the Ethernet transmit path over a second fs/fd handshake. It sits beside `cs_cmd` in `cs`, is clocked by `sys_clk`, and takes `adc_cnt` from `cs_num`.

## Interface
Parameters:
- `NUM_DEV`, 4: number of ADC devices, range 1..16.
- `TIMEOUT`, 1023: maximum cycles spent in any one handshake phase before an error is flagged.

Ports:
- `clk` in 1: system clock (`sys_clk`).
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: run enable, level-sensitive.
- `dev_mask` in NUM_DEV: bit i = 1 means device i is present and polled.
- `adc_cnt` in 8: rounds per Ethernet packet; 0 is treated as 1.
- `fifoa_full` in 1: ADC FIFO full (backpressure on ADC reads).
- `fifod_full` in 1: Ethernet FIFO full (backpressure on packet send).
- `fs_adc` out 1: ADC read request.
- `fd_adc` in 1: ADC read done.
- `dev_sel` out 4: index of the device being read.
- `fs_eth` out 1: packet transmit request.
- `fd_eth` in 1: packet transmit done.
- `busy` out 1: high in every state except IDLE.
- `round_cnt` out 8: rounds completed in the current packet.
- `pkt_cnt` out 16: packets sent; wraps modulo 2^16.
- `err_timeout` out 1: sticky timeout flag.

## Operation
- Handshake rule, for both pairs:
  - fs rises only while fd is low.
  - fs stays high until fd is sampled high, then drops.
  - The next fs waits until fd is sampled low.
- States: IDLE, SCAN, REQ, ACK, NEXT, TX, TXACK, ERR.
- IDLE:
  - Outputs low; `round_cnt` = 0; device pointer = 0.
  - `en`=1 → SCAN.
- SCAN:
  - Combinational round-robin search from the pointer (inclusive) for a set bit in `dev_mask`.
  - `dev_mask`=0 → IDLE; no handshake is issued.
  - Match and `fifoa_full`=0 → latch `dev_sel`, go to REQ.
  - Match and `fifoa_full`=1 → hold in SCAN.
- REQ: `fs_adc`=1; `fd_adc`=1 → ACK.
- ACK: `fs_adc`=0; `fd_adc`=0 → NEXT.
- NEXT:
  - Pointer = `dev_sel`+1.
  - If no set mask bit remains above `dev_sel`: round complete, pointer = 0, `round_cnt`++.
  - `round_cnt` reaches max(`adc_cnt`,1) → TX.
  - Otherwise `en`=1 → SCAN; `en`=0 → IDLE.
- TX:
  - Waits while `fifod_full`=1.
  - Then `fs_eth`=1 until `fd_eth`=1 → TXACK.
- TXACK:
  - `fs_eth`=0; `fd_eth`=0 → `pkt_cnt`++, `round_cnt`=0, pointer = 0.
  - `en`=1 → SCAN; `en`=0 → IDLE.
- `en` is sampled only in IDLE, NEXT and TXACK. An open handshake is never abandoned on `en` loss.
- `dev_mask` is sampled only in SCAN and NEXT; changes mid-handshake take effect at the next decision.
- Timeout:
  - A phase counter clears on every state change and counts in REQ, ACK, TX (after `fifod_full` clears) and TXACK.
  - Reaching `TIMEOUT` → ERR.
- ERR:
  - All fs outputs are 0; `err_timeout`=1 (sticky).
  - `en`=0 and both fd inputs low → IDLE; `err_timeout` clears on leaving ERR.
- Simultaneous round completion and `en`=0 in NEXT: TX takes priority, so the partial packet is always sent.

## Timing
- Reset: every output 0 and state IDLE, immediately on `rst` low and independent of `clk`.
- All outputs are registered.
- `en` high at edge N → SCAN after N. With `fifoa_full`=0, `fs_adc`=1 and `dev_sel` valid after edge N+1.
- `fd_adc` sampled high at edge M → `fs_adc`=0 after M.
- `fd_adc` sampled low at edge K → NEXT after K; the next `fs_adc` is high after K+2.
- Per-device overhead beyond the handshakes: 2 cycles (NEXT, SCAN).
- `pkt_cnt` and `round_cnt` update on the edge leaving TXACK and NEXT respectively.
- `round_cnt` is compared as 8-bit unsigned; `pkt_cnt` wraps 0xFFFF→0x0000 with no flag.

## Configuration
- `CS_DAT_TIMEOUT_EN` defined: phase counter, ERR state and `err_timeout` are present as described.
- `CS_DAT_TIMEOUT_EN` undefined: no counter and no ERR state; handshakes wait indefinitely; `err_timeout` is tied 0.

## Test plan
- `NUM_DEV`=4, `dev_mask`=4'b1111, `adc_cnt`=2, fd responder echoing fs with 3-cycle delay → `dev_sel` sequence 0,1,2,3,0,1,2,3, then one `fs_eth` pulse, `pkt_cnt`=1, `round_cnt`=0.
- `dev_mask`=4'b1010, `adc_cnt`=1 → `dev_sel` 1,3 then TX; devices 0 and 2 are never selected. `dev_mask`=0 with `en`=1 → `busy` pulses for 1 cycle, no `fs_adc`.
- `fifoa_full`=1 for 20 cycles in SCAN → `fs_adc` stays 0 throughout and rises 1 cycle after release. `fifod_full` held high in TX → no `fs_eth` and no timeout.
- `fd_adc` stuck 0 with `TIMEOUT`=15 → ERR 15 cycles after `fs_adc` rises, `fs_adc`=0, `err_timeout`=1. Then `en`=0 → IDLE and `err_timeout`=0. Repeat with the macro undefined → no error, `fs_adc` held.
- `en` dropped during REQ of device 1 in round 1 of `adc_cnt`=3 → handshake completes, then IDLE. Dropped during the final device of the final round → TX still completes and `pkt_cnt`++.
- `rst` low asserted mid-REQ between clock edges → `fs_adc`, `busy`, `round_cnt` and `pkt_cnt` are 0 immediately. Separately, preload `pkt_cnt`=0xFFFF (via 65535 packets) → the next packet wraps it to 0x0000.

Source files
------------

// File: rtl/cs_dat.sv
// cs_dat: round-robin ADC poller with four-phase fs/fd handshakes and per-packet Ethernet hand-off.
// Define CS_DAT_TIMEOUT_EN to build the per-phase watchdog, the ERR state and err_timeout.
module cs_dat #(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_DEV-1:0] dev_mask,
  input  logic [7:0]         adc_cnt,
  input  logic               fifoa_full,
  input  logic               fifod_full,
  output logic               fs_adc,
  input  logic               fd_adc,
  output logic [3:0]         dev_sel,
  output logic               fs_eth,
  input  logic               fd_eth,
  output logic               busy,
  output logic [7:0]         round_cnt,
  output logic [15:0]        pkt_cnt,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_REQ, S_ACK, S_NEXT, S_TX, S_TXACK, S_ERR
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   ptr_q, ptr_nxt, sel_nxt;
  logic [7:0]   rnd_nxt, tgt;
  logic [15:0]  pkt_nxt;
  logic         fs_eth_nxt;
  logic         ph_exp;

  // Rotate the mask so the search always starts at bit 0 == current pointer.
  logic [NUM_DEV-1:0] rot;
  logic [3:0]         first;
  logic               found;
  logic [4:0]         sum;
  logic [3:0]         hit_idx;

  assign rot = NUM_DEV'({dev_mask, dev_mask} >> ptr_q);

  always_comb begin
    first = '0;
    found = 1'b0;
    for (int k = NUM_DEV-1; k >= 0; k--)
      if (rot[k]) begin
        first = 4'(k);
        found = 1'b1;
      end
  end

  assign sum     = {1'b0, ptr_q} + {1'b0, first};
  assign hit_idx = (sum >= 5'(NUM_DEV)) ? 4'(sum - 5'(NUM_DEV)) : sum[3:0];

  // Devices still pending in this round: present and above the one just read.
  logic [NUM_DEV-1:0] above_bits;
  logic               more_left;
  for (genvar i = 0; i < NUM_DEV; i++) begin : g_above
    assign above_bits[i] = dev_mask[i] & (4'(i) > dev_sel);
  end
  assign more_left = |above_bits;

  assign tgt = (adc_cnt == 8'd0) ? 8'd1 : adc_cnt;

`ifdef CS_DAT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] ph_cnt;
  logic          ph_run;

  // TX only counts once the Ethernet FIFO has room, so backpressure never trips it.
  assign ph_run = (state == S_REQ) || (state == S_ACK) || (state == S_TXACK) ||
                  ((state == S_TX) && (fs_eth || !fifod_full));
  assign ph_exp = ph_run && (ph_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    ph_cnt <= '0;
    else if (state_nxt != state) ph_cnt <= '0;
    else if (ph_run)             ph_cnt <= ph_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_timeout <= 1'b0;
    else      err_timeout <= (state_nxt == S_ERR);
  end
`else
  assign ph_exp      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr_q;
    sel_nxt    = dev_sel;
    rnd_nxt    = round_cnt;
    pkt_nxt    = pkt_cnt;
    fs_eth_nxt = 1'b0;
    case (state)
      S_IDLE:  if (en) state_nxt = S_SCAN;
      S_SCAN: begin
        if (!found) state_nxt = S_IDLE;
        else if (!fifoa_full && !fd_adc) begin
          sel_nxt   = hit_idx;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (fd_adc)      state_nxt = S_ACK;
        else if (ph_exp) state_nxt = S_ERR;
      end
      S_ACK: begin
        if (!fd_adc)     state_nxt = S_NEXT;
        else if (ph_exp) state_nxt = S_ERR;
      end
      S_NEXT: begin
        if (more_left) ptr_nxt = dev_sel + 4'd1;
        else begin
          ptr_nxt = '0;
          rnd_nxt = round_cnt + 8'd1;
        end
        // A finished packet is sent even when en has dropped.
        if (!more_left && (rnd_nxt >= tgt)) state_nxt = S_TX;
        else if (en)                        state_nxt = S_SCAN;
        else                                state_nxt = S_IDLE;
      end
      S_TX: begin
        if (fs_eth && fd_eth) state_nxt = S_TXACK;
        else if (ph_exp)      state_nxt = S_ERR;
        else                  fs_eth_nxt = fs_eth || (!fifod_full && !fd_eth);
      end
      S_TXACK: begin
        if (!fd_eth) begin
          pkt_nxt   = pkt_cnt + 16'd1;
          rnd_nxt   = '0;
          ptr_nxt   = '0;
          state_nxt = en ? S_SCAN : S_IDLE;
        end else if (ph_exp) state_nxt = S_ERR;
      end
`ifdef CS_DAT_TIMEOUT_EN
      S_ERR: if (!en && !fd_adc && !fd_eth) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_IDLE) begin
      ptr_nxt = '0;
      sel_nxt = '0;
      rnd_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr_q     <= '0;
      dev_sel   <= '0;
      round_cnt <= '0;
      pkt_cnt   <= '0;
      fs_adc    <= 1'b0;
      fs_eth    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr_q     <= ptr_nxt;
      dev_sel   <= sel_nxt;
      round_cnt <= rnd_nxt;
      pkt_cnt   <= pkt_nxt;
      fs_adc    <= (state_nxt == S_REQ);
      fs_eth    <= fs_eth_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule
